// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel down-counting timer.
package timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter with snapshot reload, one-cycle int pulse and sticky pending flag.
//  state | meaning
//  IDLE  | stopped, waiting for start
//  RUN   | counting down on each prescaler tick, expiring after count reaches zero
module timer_channel
   import timer_pkg::*;
#(
   parameter int DATA_WIDTH = 13
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   input  logic                  tick_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  mode_i,
   input  logic [DATA_WIDTH-1:0] load_i,
   input  logic                  ack_i,
   output logic                  int_o,
   output logic                  pending_o,
   output logic                  busy_o
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] snap_q, snap_d;
   logic                  mode_q, mode_d;
   logic                  int_q, int_d;
   logic                  pend_q, pend_d;

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         snap_q  <= '0;
         mode_q  <= MODE_ONESHOT;
         int_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         mode_q  <= mode_d;
         int_q   <= int_d;
         pend_q  <= pend_d;
      end
   end

   // Stop beats start, start beats counting; a retrigger discards the old count silently.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      mode_d  = mode_q;
      int_d   = 1'b0;
      if (stop_i) begin
         state_d = IDLE;
      end else if (start_i) begin
         state_d = RUN;
         cnt_d   = load_i;
         snap_d  = load_i;
         mode_d  = mode_i;
      end else if (state_q == RUN && tick_i) begin
         if (cnt_q == '0) begin
            int_d = 1'b1;
            if (mode_q == MODE_PERIODIC) begin
               cnt_d = snap_q;
            end else begin
               state_d = IDLE;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
      pend_d = int_d | (pend_q & ~ack_i);
   end

   assign int_o     = int_q;
   assign pending_o = pend_q;
   assign busy_o    = (state_q == RUN);

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer top: shared prescaler, per-channel load slicing and irq OR-reduction.
module timer_multi
   import timer_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int DATA_WIDTH = 13,
   parameter int PRESCALE   = 1
) (
   input  logic                           clock_in,
   input  logic                           reset_in,
   input  logic [CHANNELS-1:0]            start_in,
   input  logic [CHANNELS-1:0]            stop_in,
   input  logic [CHANNELS-1:0]            mode_in,
   input  logic [CHANNELS*DATA_WIDTH-1:0] load_in,
   input  logic [CHANNELS-1:0]            ack_in,
   output logic [CHANNELS-1:0]            int_out,
   output logic [CHANNELS-1:0]            pending_out,
   output logic [CHANNELS-1:0]            busy_out,
   output logic                           irq_out
);

   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   // With PRESCALE = 1 the counter sits at 0 == PRE_LAST, so tick is always high.
   assign tick  = (pre_q == PRE_LAST);
   assign pre_d = tick ? '0 : pre_q + 1'b1;

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      timer_channel #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_ch (
         .clock_in (clock_in),
         .reset_in (reset_in),
         .tick_i   (tick),
         .start_i  (start_in[i]),
         .stop_i   (stop_in[i]),
         .mode_i   (mode_in[i]),
         .load_i   (load_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .ack_i    (ack_in[i]),
         .int_o    (int_out[i]),
         .pending_o(pending_out[i]),
         .busy_o   (busy_out[i])
      );
   end

   assign irq_out = |pending_out;

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench: two timer_multi instances (PRESCALE 1 and 4) fed the same stimulus,
// compared every cycle against a deadline-based reference model, plus directed sequences.
module tb_timer_multi;

   localparam int CH = 4;
   localparam int DW = 13;

   logic             clk = 1'b0;
   logic             reset_in = 1'b0;
   logic [CH-1:0]    start_v = '0, stop_v = '0, mode_v = '0, ack_v = '0;
   logic [CH*DW-1:0] load_v = '0;

   logic [CH-1:0] int_p1, pend_p1, busy_p1, int_p4, pend_p4, busy_p4;
   logic          irq_p1, irq_p4;

   always #5 clk = ~clk;

   timer_multi #(.CHANNELS(CH), .DATA_WIDTH(DW), .PRESCALE(1)) dut_p1 (
      .clock_in(clk), .reset_in(reset_in), .start_in(start_v), .stop_in(stop_v),
      .mode_in(mode_v), .load_in(load_v), .ack_in(ack_v), .int_out(int_p1),
      .pending_out(pend_p1), .busy_out(busy_p1), .irq_out(irq_p1));

   timer_multi #(.CHANNELS(CH), .DATA_WIDTH(DW), .PRESCALE(4)) dut_p4 (
      .clock_in(clk), .reset_in(reset_in), .start_in(start_v), .stop_in(stop_v),
      .mode_in(mode_v), .load_in(load_v), .ack_in(ack_v), .int_out(int_p4),
      .pending_out(pend_p4), .busy_out(busy_p4), .irq_out(irq_p4));

   int checks = 0;
   int errors = 0;

   // Reference model: each running channel holds the absolute edge index of its next expiry.
   bit     m_run [2][CH];
   longint m_dl  [2][CH];
   int     m_L   [2][CH];
   bit     m_mode[2][CH];
   bit     m_pend[2][CH];
   bit     m_int [2][CH];
   longint ec = 0;
   longint cyc_n = 0;

   typedef struct {
      int ch;
      bit mode;
      int L;
      int exp_delay;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc_n);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < CH; c++) begin
            m_run[d][c] = 0; m_dl[d][c] = 0; m_L[d][c] = 0;
            m_mode[d][c] = 0; m_pend[d][c] = 0; m_int[d][c] = 0;
         end
   endtask

   task automatic model_step(input longint k);
      longint p, f;
      for (int d = 0; d < 2; d++) begin
         p = (d == 0) ? 1 : 4;
         for (int c = 0; c < CH; c++) begin
            m_int[d][c] = 0;
            if (stop_v[c]) begin
               m_run[d][c] = 0;
            end else if (start_v[c]) begin
               m_run[d][c]  = 1;
               m_L[d][c]    = int'(load_v[c*DW +: DW]);
               m_mode[d][c] = mode_v[c];
               f = k + 1;
               while (f % p != p - 1) f++;
               m_dl[d][c] = f + longint'(m_L[d][c]) * p;
            end else if (m_run[d][c] && k == m_dl[d][c]) begin
               m_int[d][c] = 1;
               if (m_mode[d][c]) m_dl[d][c] += longint'(m_L[d][c] + 1) * p;
               else              m_run[d][c] = 0;
            end
            if (m_int[d][c])  m_pend[d][c] = 1;
            else if (ack_v[c]) m_pend[d][c] = 0;
         end
      end
   endtask

   task automatic cyc();
      logic [CH-1:0] ei, eb, ep, ai, ab, ap;
      logic          air;
      @(posedge clk);
      if (!reset_in) begin
         model_clear();
         ec = 0;
      end else begin
         model_step(ec);
         ec++;
      end
      cyc_n++;
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < CH; c++) begin
            ei[c] = m_int[d][c]; eb[c] = m_run[d][c]; ep[c] = m_pend[d][c];
         end
         ai  = (d == 0) ? int_p1  : int_p4;
         ab  = (d == 0) ? busy_p1 : busy_p4;
         ap  = (d == 0) ? pend_p1 : pend_p4;
         air = (d == 0) ? irq_p1  : irq_p4;
         chk($sformatf("int_out[p%0d]", d * 3 + 1), 32'(ai), 32'(ei));
         chk($sformatf("busy_out[p%0d]", d * 3 + 1), 32'(ab), 32'(eb));
         chk($sformatf("pending_out[p%0d]", d * 3 + 1), 32'(ap), 32'(ep));
         chk($sformatf("irq_out[p%0d]", d * 3 + 1), 32'(air), 32'(|ep));
      end
   endtask

   task automatic start_ch(input int c, input bit m, input int l);
      start_v[c] = 1'b1;
      mode_v[c]  = m;
      load_v[c*DW +: DW] = DW'(l);
      cyc();
      start_v[c] = 1'b0;
   endtask

   // Cycles from the edge after the start edge until int_out of the PRESCALE=1 DUT is seen.
   task automatic wait_int1(input int c, input int limit, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!int_p1[c] && n < limit);
   endtask

   initial begin
      vec_t tbl[5];
      int   n, cnt, first;
      longint pulses[6];
      int   fst[CH];
      int   lv[CH];

      tbl[0] = '{ch: 0, mode: 1'b0, L: 5,    exp_delay: 6};
      tbl[1] = '{ch: 1, mode: 1'b0, L: 0,    exp_delay: 1};
      tbl[2] = '{ch: 2, mode: 1'b0, L: 9,    exp_delay: 10};
      tbl[3] = '{ch: 3, mode: 1'b0, L: 8191, exp_delay: 8192};
      tbl[4] = '{ch: 0, mode: 1'b1, L: 3,    exp_delay: 4};

      model_clear();
      repeat (3) cyc();
      reset_in = 1'b1;
      repeat (6) cyc();

      // Table: first-pulse latency, then sticky pending and ack
      for (int i = 0; i < 5; i++) begin
         start_ch(tbl[i].ch, tbl[i].mode, tbl[i].L);
         wait_int1(tbl[i].ch, tbl[i].exp_delay + 20, n);
         chk($sformatf("tbl%0d_delay", i), 32'(n), 32'(tbl[i].exp_delay));
         if (tbl[i].mode) begin
            stop_v[tbl[i].ch] = 1'b1;
            cyc();
            stop_v[tbl[i].ch] = 1'b0;
         end
         repeat (2) cyc();
         chk($sformatf("tbl%0d_pend_hold", i), 32'(pend_p1[tbl[i].ch]), 32'd1);
         ack_v[tbl[i].ch] = 1'b1;
         cyc();
         ack_v[tbl[i].ch] = 1'b0;
         chk($sformatf("tbl%0d_pend_ack", i), 32'(pend_p1[tbl[i].ch]), 32'd0);
      end

      // Periodic with prescaler 4, L = 2: pulses every 12 cycles, then stop
      start_ch(1, 1'b1, 2);
      cnt = 0;
      for (int i = 0; i < 120 && cnt < 6; i++) begin
         cyc();
         if (int_p4[1]) begin
            pulses[cnt] = cyc_n;
            cnt++;
         end
      end
      chk("p4_pulse_count", 32'(cnt), 32'd6);
      for (int i = 1; i < 6; i++)
         chk($sformatf("p4_interval%0d", i), 32'(pulses[i] - pulses[i-1]), 32'd12);
      stop_v[1] = 1'b1;
      cyc();
      stop_v[1] = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (int_p4[1]) cnt++;
      end
      chk("p4_after_stop", 32'(cnt), 32'd0);
      chk("p4_busy_after_stop", 32'(busy_p4[1]), 32'd0);

      // Retrigger: L = 10, restart with L = 2 when the count is 3
      start_ch(2, 1'b0, 10);
      repeat (7) cyc();
      start_ch(2, 1'b0, 2);
      cnt = 0;
      first = -1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (int_p1[2]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      chk("retrig_delay", 32'(first), 32'd3);
      chk("retrig_count", 32'(cnt), 32'd1);

      // Stop coinciding with expiry
      start_ch(2, 1'b0, 3);
      repeat (3) cyc();
      stop_v[2] = 1'b1;
      cyc();
      stop_v[2] = 1'b0;
      chk("stop_expiry_int", 32'(int_p1[2]), 32'd0);
      chk("stop_expiry_busy", 32'(busy_p1[2]), 32'd0);
      cyc();
      chk("stop_expiry_int_late", 32'(int_p1[2]), 32'd0);

      // Start and stop on the same edge
      start_v[3] = 1'b1;
      stop_v[3]  = 1'b1;
      load_v[3*DW +: DW] = DW'(4);
      cyc();
      start_v[3] = 1'b0;
      stop_v[3]  = 1'b0;
      chk("start_stop_busy_p1", 32'(busy_p1[3]), 32'd0);
      chk("start_stop_busy_p4", 32'(busy_p4[3]), 32'd0);

      // All channels concurrently with different loads
      lv = '{1, 4, 7, 10};
      for (int c = 0; c < CH; c++) begin
         start_v[c] = 1'b1;
         mode_v[c]  = 1'b0;
         load_v[c*DW +: DW] = DW'(lv[c]);
         fst[c] = -1;
      end
      cyc();
      start_v = '0;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         for (int c = 0; c < CH; c++)
            if (int_p1[c] && fst[c] < 0) fst[c] = i;
      end
      for (int c = 0; c < CH; c++)
         chk($sformatf("concurrent_ch%0d", c), 32'(fst[c]), 32'(lv[c] + 1));
      chk("concurrent_irq", 32'(irq_p1), 32'd1);
      ack_v = '1;
      cyc();
      ack_v = '0;

      // Ack and set on the same edge: set wins
      start_ch(0, 1'b0, 2);
      repeat (2) cyc();
      ack_v[0] = 1'b1;
      cyc();
      ack_v[0] = 1'b0;
      chk("ack_set_int", 32'(int_p1[0]), 32'd1);
      chk("ack_set_pend", 32'(pend_p1[0]), 32'd1);

      // Asynchronous reset while channels run
      for (int c = 0; c < CH; c++) begin
         start_v[c] = 1'b1;
         mode_v[c]  = 1'b1;
         load_v[c*DW +: DW] = DW'(c + 2);
      end
      cyc();
      start_v = '0;
      repeat (4) cyc();
      #2 reset_in = 1'b0;
      #1;
      chk("arst_int_p1",  32'(int_p1),  32'd0);
      chk("arst_busy_p1", 32'(busy_p1), 32'd0);
      chk("arst_pend_p1", 32'(pend_p1), 32'd0);
      chk("arst_irq_p1",  32'(irq_p1),  32'd0);
      chk("arst_busy_p4", 32'(busy_p4), 32'd0);
      chk("arst_pend_p4", 32'(pend_p4), 32'd0);
      repeat (2) cyc();
      reset_in = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         cnt += int'($countones(int_p1)) + int'($countones(int_p4));
      end
      chk("arst_no_int", 32'(cnt), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < CH; c++) begin
            start_v[c] = ($urandom_range(0, 15) == 0);
            stop_v[c]  = ($urandom_range(0, 31) == 0);
            ack_v[c]   = ($urandom_range(0, 3) == 0);
            mode_v[c]  = 1'($urandom_range(0, 1));
            load_v[c*DW +: DW] = DW'($urandom_range(0, 12));
         end
         cyc();
      end
      start_v = '0;
      stop_v  = '0;
      ack_v   = '0;
      repeat (60) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
